receiver_spi: RTL
=================

Name: receiver_SPI

Overview:
- SPI peripheral (slave) end of the link driven by the SPI transmitter (master).
- Oversamples SCK, CS and MOSI on the local system clock.
- Shifts in 8-bit frames MSB-first and returns a byte on MISO, full-duplex.
- Supports all four CKP/CPH modes and back-to-back bytes while CS stays low.

Parameters:
- WIDTH, 8, frame length in bits (the bit counter is sized clog2(WIDTH)).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (SCK, CS, MOSI).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- CPH  input  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
- CKP  input  1  clock polarity; idle level of SCK.
- CS  input  1  chip select, active low, asynchronous to clk.
- SCK  input  1  serial clock from master, asynchronous to clk.
- MOSI  input  1  serial data from master.
- data_in  input  WIDTH  byte to return to master; captured at frame start and at each byte boundary.
- MISO  output  1  serial data to master.
- data_out  output  WIDTH  last complete byte received.
- rx_valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset values: MISO=0, data_out=0, rx_valid=0, busy=0, bit counter=0, state IDLE. All synchronizer flops are cleared to their idle values (SCK=CKP, CS=1).
- Synchronizers: SCK, CS and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronized SCK against a 1-cycle delayed copy. SCK high and low phases are each ≥ 4 clk periods (system constraint, not checked).
- Leading edge = synced SCK leaving CKP. Trailing edge = synced SCK returning to CKP.
- Sample edge is the leading edge if CPH=0, the trailing edge if CPH=1. The shift edge is the opposite edge. CPH and CKP are static while CS is low.
- FSM states:
  - IDLE: wait for the synced CS falling edge.
  - LOAD: one cycle; tx_shift<=data_in, rx_shift cleared, count<=0. If CPH=0, MISO<=data_in[WIDTH-1].
  - SHIFT: stays here until the frame ends.
  - Transitions: IDLE->LOAD on CS fall; LOAD->SHIFT unconditionally; SHIFT->IDLE on synced CS high.
- busy=1 in LOAD and SHIFT.
- Sample edge (in SHIFT): rx_shift<={rx_shift[WIDTH-2:0], MOSI_sync}, count++.
  - When count reaches WIDTH-1 at this edge: data_out<=completed byte and rx_valid=1 on the next cycle, exactly one cycle. Then count<=0.
- Shift edge (in SHIFT):
  - CPH=0: MISO<=next bit of tx_shift. On the shift edge after the last bit, reload tx_shift<=data_in and drive its MSB.
  - CPH=1: at each leading edge MISO<=tx_shift MSB and tx_shift shifts left. Reload from data_in when count==0 at the first leading edge of each byte.
- MISO in IDLE: held at 0.
- CS rising mid-byte (count≠0): abort. The partial byte is discarded, data_out is unchanged, no rx_valid, return to IDLE, MISO=0.
- Simultaneous CS rise and a sample edge in the same cycle: CS wins; the edge is ignored.
- Extra SCK edges while CS is high: ignored.
- rst asserted mid-frame: everything returns to reset values on the next clk edge. After rst is released, a frame starts only on a new CS falling edge; CS already low at release does not start a frame.
- Latency: the SCK pin edge to the internal sample is SYNC_STAGES+1 clk cycles. rx_valid fires one cycle after the final sample.

Test Plan:
- Mode 0 (CKP=0, CPH=0): master sends 0xA5, data_in=0x3C.
  -> data_out=0xA5, one rx_valid pulse, master receives 0x3C, busy falls after CS rises.
- Mode 3 (CKP=1, CPH=1): master sends 0x81, data_in=0x7E.
  -> data_out=0x81, MISO bit sequence 0,1,1,1,1,1,1,0 on the sample edges.
- Back-to-back bytes 0x12, 0x34 under one CS low, data_in changed 0x55->0xAA between them.
  -> two rx_valid pulses, data_out 0x12 then 0x34, master receives 0x55 then 0xAA.
- CS raised after 4 bits of 0xF0.
  -> no rx_valid, data_out keeps its prior value, state IDLE, MISO=0. The next full frame of 0x0F yields 0x0F.
- rst pulsed during bit 5 of a frame, then a fresh CS-framed 0xC3.
  -> all outputs are 0 after reset, and 0xC3 is received correctly.
- Modes 1 and 2, each with 0x5A/0xA5.
  -> correct exchange in both directions. SCK toggling with CS high produces no rx_valid.

Source files
------------

// File: rtl/receiver_spi.sv
// rtl/receiver_spi.sv - SPI peripheral: oversampled SCK/CS/MOSI, MSB-first full-duplex frames, all CKP/CPH modes
module receiver_spi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CPH,
    input  logic             CKP,
    input  logic             CS,
    input  logic             SCK,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] data_in,
    output logic             MISO,
    output logic [WIDTH-1:0] data_out,
    output logic             rx_valid,
    output logic             busy
);
    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int             SW     = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0]  SETTLE = SW'(SYNC_STAGES + 1);
    localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic [SW-1:0]          settle_q;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   miso_q, miso_d;
    logic [WIDTH-1:0]       data_out_q, data_out_d;
    logic                   rx_valid_q, rx_valid_d;

    logic             sck_s, cs_s, mosi_s;
    logic             leading, trailing, sample_edge, shift_edge, cs_fall;
    logic [WIDTH-1:0] rx_next, tx_src;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign leading     = (sck_s != sck_prev_q) && (sck_s != CKP);
    assign trailing    = (sck_s != sck_prev_q) && (sck_s == CKP);
    assign sample_edge = CPH ? trailing : leading;
    assign shift_edge  = CPH ? leading : trailing;
    // The synchronizer still holds reset values for a few cycles after rst;
    // a CS fall seen during that window is only the pin level settling in.
    assign cs_fall     = cs_prev_q && !cs_s && (settle_q == SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= {SYNC_STAGES{CKP}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= CKP;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
        end else begin
            sck_sync_q  <= SYNC_STAGES'({sck_sync_q, SCK});
            cs_sync_q   <= SYNC_STAGES'({cs_sync_q, CS});
            mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, MOSI});
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            if (settle_q != SETTLE) begin
                settle_q <= settle_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            count_q    <= '0;
            miso_q     <= 1'b0;
            data_out_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            count_q    <= count_d;
            miso_q     <= miso_d;
            data_out_q <= data_out_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        count_d    = count_q;
        miso_d     = miso_q;
        data_out_d = data_out_q;
        rx_valid_d = 1'b0;
        rx_next    = {rx_shift_q[WIDTH-2:0], mosi_s};
        tx_src     = (count_q == '0) ? data_in : tx_shift_q;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_shift_d = data_in;
                rx_shift_d = '0;
                count_d    = '0;
                if (!CPH) begin
                    miso_d = data_in[WIDTH-1];
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cs_s) begin
                    // CS release wins over any edge seen in the same cycle
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (count_q == LAST) begin
                            data_out_d = rx_next;
                            rx_valid_d = 1'b1;
                            count_d    = '0;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (CPH) begin
                            miso_d     = tx_src[WIDTH-1];
                            tx_shift_d = tx_src << 1;
                        end else if (count_q == '0) begin
                            tx_shift_d = data_in;
                            miso_d     = data_in[WIDTH-1];
                        end else begin
                            miso_d     = tx_shift_q[WIDTH-2];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MISO     = miso_q;
    assign data_out = data_out_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);

endmodule
